// File: rtl/fp_compare_pipe_if.sv
// Handshake bundle for the pipelined FP comparator: issue side (in_*) and
// writeback side (out_*). The slave modport is the comparator's own view.
interface fp_compare_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_operand;
    logic [W-1:0] b_operand;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_rel;
    logic         out_nv;

    modport slave (
        input  in_valid, a_operand, b_operand, op, out_ready,
        output in_ready, out_valid, out_data, out_rel, out_nv
    );

    modport master (
        output in_valid, a_operand, b_operand, op, out_ready,
        input  in_ready, out_valid, out_data, out_rel, out_nv
    );
endinterface

// File: rtl/fp_compare_pipe.sv
// Two-stage IEEE-754 comparator: S1 holds operand classes and the ordered
// relation, S2 selects the FEQ/FLT/FLE/FMIN/FMAX/CMP result.
module fp_compare_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    fp_compare_pipe_if.slave   bus
);
    localparam int W = 1 + EXP_W + MAN_W;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_SNAN   = 2'd1,
        CLS_QNAN   = 2'd2,
        CLS_NORMAL = 2'd3
    } fp_class_e;

    typedef enum logic [2:0] {
        OP_FEQ  = 3'b000,
        OP_FLT  = 3'b001,
        OP_FLE  = 3'b010,
        OP_FMIN = 3'b011,
        OP_FMAX = 3'b100,
        OP_CMP  = 3'b101
    } op_e;

    localparam logic [1:0] REL_EQ = 2'b00;
    localparam logic [1:0] REL_GT = 2'b01;
    localparam logic [1:0] REL_LT = 2'b10;
    localparam logic [1:0] REL_UN = 2'b11;

    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic fp_class_e classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = x[W-2:MAN_W];
        m = x[MAN_W-1:0];
        if (&e && (m != '0))
            classify = m[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
        else if ((e == '0) && (m == '0))
            classify = CLS_ZERO;
        else
            classify = CLS_NORMAL;
    endfunction

    logic         s1_valid_q, s1_valid_d;
    op_e          s1_op_q, s1_op_d;
    logic [W-1:0] s1_a_q, s1_a_d;
    logic [W-1:0] s1_b_q, s1_b_d;
    fp_class_e    s1_a_cls_q, s1_a_cls_d;
    fp_class_e    s1_b_cls_q, s1_b_cls_d;
    logic [1:0]   s1_rel_q, s1_rel_d;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [1:0]   out_rel_q, out_rel_d;
    logic         out_nv_q, out_nv_d;

    logic         ready_en_q, ready_en_d;

    logic         s2_adv, s1_adv, in_ready, take;
    fp_class_e    in_a_cls, in_b_cls;
    logic [1:0]   in_rel;
    logic [W-1:0] res_data;
    logic         res_nv;

    // Sign-aware ordering of the incoming operands; zeros of either sign tie.
    always_comb begin
        in_a_cls = classify(bus.a_operand);
        in_b_cls = classify(bus.b_operand);
        in_rel   = REL_EQ;
        if ((in_a_cls inside {CLS_SNAN, CLS_QNAN}) || (in_b_cls inside {CLS_SNAN, CLS_QNAN}))
            in_rel = REL_UN;
        else if ((in_a_cls == CLS_ZERO) && (in_b_cls == CLS_ZERO))
            in_rel = REL_EQ;
        else if (bus.a_operand[W-1] != bus.b_operand[W-1])
            in_rel = bus.a_operand[W-1] ? REL_LT : REL_GT;
        else if (bus.a_operand[W-2:0] == bus.b_operand[W-2:0])
            in_rel = REL_EQ;
        else if ((bus.a_operand[W-2:0] > bus.b_operand[W-2:0]) ^ bus.a_operand[W-1])
            in_rel = REL_GT;
        else
            in_rel = REL_LT;
    end

    always_comb begin
        logic a_nan, b_nan, any_snan, a_lt, a_gt;
        a_nan    = s1_a_cls_q inside {CLS_SNAN, CLS_QNAN};
        b_nan    = s1_b_cls_q inside {CLS_SNAN, CLS_QNAN};
        any_snan = (s1_a_cls_q == CLS_SNAN) || (s1_b_cls_q == CLS_SNAN);
        // -0 orders below +0 for min/max even though the relation says equal.
        a_lt     = (s1_rel_q == REL_LT) || ((s1_rel_q == REL_EQ) && s1_a_q[W-1] && !s1_b_q[W-1]);
        a_gt     = (s1_rel_q == REL_GT) || ((s1_rel_q == REL_EQ) && !s1_a_q[W-1] && s1_b_q[W-1]);
        res_data = '0;
        res_nv   = 1'b0;
        case (s1_op_q)
            OP_FEQ: begin
                res_data[0] = (s1_rel_q == REL_EQ);
                res_nv      = any_snan;
            end
            OP_FLT: begin
                res_data[0] = (s1_rel_q == REL_LT);
                res_nv      = a_nan || b_nan;
            end
            OP_FLE: begin
                res_data[0] = (s1_rel_q == REL_LT) || (s1_rel_q == REL_EQ);
                res_nv      = a_nan || b_nan;
            end
            OP_FMIN, OP_FMAX: begin
                res_nv = any_snan;
                if (a_nan && b_nan)
                    res_data = CANON_NAN;
                else if (a_nan)
                    res_data = s1_b_q;
                else if (b_nan)
                    res_data = s1_a_q;
                else if (s1_op_q == OP_FMIN)
                    res_data = a_lt ? s1_a_q : s1_b_q;
                else
                    res_data = a_gt ? s1_a_q : s1_b_q;
            end
            default: begin
                res_data[1:0] = s1_rel_q;
            end
        endcase
    end

    // Handshake and stage enables; flush wins over any same-cycle transfer.
    always_comb begin
        s2_adv   = !out_valid_q || bus.out_ready;
        s1_adv   = s2_adv || !s1_valid_q;
        in_ready = ready_en_q && s1_adv;
        take     = bus.in_valid && in_ready;

        ready_en_d  = 1'b1;
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_a_cls_d  = s1_a_cls_q;
        s1_b_cls_d  = s1_b_cls_q;
        s1_rel_d    = s1_rel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rel_d   = out_rel_q;
        out_nv_d    = out_nv_q;

        if (s1_adv)
            s1_valid_d = take;
        if (take) begin
            s1_op_d    = op_e'(bus.op);
            s1_a_d     = bus.a_operand;
            s1_b_d     = bus.b_operand;
            s1_a_cls_d = in_a_cls;
            s1_b_cls_d = in_b_cls;
            s1_rel_d   = in_rel;
        end
        if (s2_adv)
            out_valid_d = s1_valid_q;
        if (s2_adv && s1_valid_q) begin
            out_data_d = res_data;
            out_rel_d  = s1_rel_q;
            out_nv_d   = res_nv;
        end
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_FEQ;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_a_cls_q  <= CLS_ZERO;
            s1_b_cls_q  <= CLS_ZERO;
            s1_rel_q    <= REL_EQ;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rel_q   <= REL_EQ;
            out_nv_q    <= 1'b0;
        end else begin
            ready_en_q  <= ready_en_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_a_cls_q  <= s1_a_cls_d;
            s1_b_cls_q  <= s1_b_cls_d;
            s1_rel_q    <= s1_rel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rel_q   <= out_rel_d;
            out_nv_q    <= out_nv_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_rel   = out_rel_q;
    assign bus.out_nv    = out_nv_q;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed bench for fp_compare_pipe (single precision): vector table plus
// stall, flush and mid-stream reset sequences.
module tb_fp_compare_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] data;
        logic [1:0]  rel;
        logic        nv;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[20];
    vec_t stall_vecs[4];

    fp_compare_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus_if ();

    fp_compare_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input logic [31:0] d,
                                input logic [1:0] r, input logic nv);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.op = op; v.data = d; v.rel = r; v.nv = nv;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the op.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bit accepted = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.a_operand = a;
        bus_if.b_operand = b;
        bus_if.op        = op;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = bus_if.in_ready;
            @(posedge clk);
            #1;
        end
        bus_if.in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v.a, v.b, v.op);
        @(negedge clk);
        checkOutput({v.name, "_early_valid"}, {31'd0, bus_if.out_valid}, 32'd0);
        @(negedge clk);
        checkOutput({v.name, "_valid"}, {31'd0, bus_if.out_valid}, 32'd1);
        checkOutput({v.name, "_data"}, bus_if.out_data, v.data);
        checkOutput({v.name, "_rel"}, {30'd0, bus_if.out_rel}, {30'd0, v.rel});
        checkOutput({v.name, "_nv"}, {31'd0, bus_if.out_nv}, {31'd0, v.nv});
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string name, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus_if.out_valid) seen = 1'b1;
        end
        checkOutput(name, {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic stallSequence();
        int  got = 0;
        int  xfer_cyc[4];
        bit  saw_stall = 1'b0;
        bit  held = 1'b0;
        logic [31:0] held_data = '0;
        bus_if.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    applyStimulus(stall_vecs[i].a, stall_vecs[i].b, stall_vecs[i].op);
            end
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = bus_if.out_valid;
                end
                @(posedge clk);
                #1 bus_if.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus_if.out_ready = 1'b1;
            end
            begin
                for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                    @(negedge clk);
                    if (bus_if.in_valid && !bus_if.in_ready) saw_stall = 1'b1;
                    if (bus_if.out_valid) begin
                        if (held) checkOutput("stall_hold", bus_if.out_data, held_data);
                        if (bus_if.out_ready) begin
                            checkOutput({stall_vecs[got].name, "_data"}, bus_if.out_data, stall_vecs[got].data);
                            checkOutput({stall_vecs[got].name, "_rel"}, {30'd0, bus_if.out_rel}, {30'd0, stall_vecs[got].rel});
                            xfer_cyc[got] = cyc;
                            got++;
                            held = 1'b0;
                        end else begin
                            held = 1'b1;
                            held_data = bus_if.out_data;
                        end
                    end else begin
                        held = 1'b0;
                    end
                end
            end
        join
        checkOutput("stall_count", got, 32'd4);
        checkOutput("stall_in_ready_drop", {31'd0, saw_stall}, 32'd1);
        if (got == 4) checkOutput("stall_drain_rate", xfer_cyc[3] - xfer_cyc[1], 32'd2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = mk("flt_1_2",      32'h3F800000, 32'h40000000, 3'b001, 32'h1,        2'b10, 1'b0);
        vecs[1]  = mk("feq_zeros",    32'h00000000, 32'h80000000, 3'b000, 32'h1,        2'b00, 1'b0);
        vecs[2]  = mk("fmin_zeros",   32'h00000000, 32'h80000000, 3'b011, 32'h80000000, 2'b00, 1'b0);
        vecs[3]  = mk("fle_qnan",     32'h7FC00000, 32'hBF800000, 3'b010, 32'h0,        2'b11, 1'b1);
        vecs[4]  = mk("feq_qnan",     32'h7FC00000, 32'hBF800000, 3'b000, 32'h0,        2'b11, 1'b0);
        vecs[5]  = mk("fmax_snan",    32'h7F800001, 32'hC0000000, 3'b100, 32'hC0000000, 2'b11, 1'b1);
        vecs[6]  = mk("fmax_2qnan",   32'h7FC00000, 32'h7FC00000, 3'b100, 32'h7FC00000, 2'b11, 1'b0);
        vecs[7]  = mk("cmp_gt",       32'h40000000, 32'h3F800000, 3'b101, 32'h1,        2'b01, 1'b0);
        vecs[8]  = mk("cmp_neg_lt",   32'hC0000000, 32'hBF800000, 3'b101, 32'h2,        2'b10, 1'b0);
        vecs[9]  = mk("fmax_zeros",   32'h80000000, 32'h00000000, 3'b100, 32'h00000000, 2'b00, 1'b0);
        vecs[10] = mk("flt_snan",     32'h7F800001, 32'h3F800000, 3'b001, 32'h0,        2'b11, 1'b1);
        vecs[11] = mk("feq_snan",     32'h7F800001, 32'h7F800001, 3'b000, 32'h0,        2'b11, 1'b1);
        vecs[12] = mk("fmin_2nan",    32'h7FA00000, 32'h7FC00000, 3'b011, 32'h7FC00000, 2'b11, 1'b1);
        vecs[13] = mk("rsvd_op_eq",   32'h3F800000, 32'h3F800000, 3'b111, 32'h0,        2'b00, 1'b0);
        vecs[14] = mk("flt_subnorm",  32'h00000001, 32'h00000002, 3'b001, 32'h1,        2'b10, 1'b0);
        vecs[15] = mk("fle_equal",    32'h3F800000, 32'h3F800000, 3'b010, 32'h1,        2'b00, 1'b0);
        vecs[16] = mk("fmin_signs",   32'h3F800000, 32'hBF800000, 3'b011, 32'hBF800000, 2'b01, 1'b0);
        vecs[17] = mk("flt_inf",      32'h7F7FFFFF, 32'h7F800000, 3'b001, 32'h1,        2'b10, 1'b0);
        vecs[18] = mk("fmin_qnan",    32'h7FC00000, 32'h3F800000, 3'b011, 32'h3F800000, 2'b11, 1'b0);
        vecs[19] = mk("fle_negzero",  32'h80000000, 32'h00000000, 3'b010, 32'h1,        2'b00, 1'b0);
        stall_vecs[0] = vecs[0];
        stall_vecs[1] = vecs[5];
        stall_vecs[2] = vecs[7];
        stall_vecs[3] = vecs[16];

        bus_if.in_valid  = 1'b0;
        bus_if.a_operand = '0;
        bus_if.b_operand = '0;
        bus_if.op        = 3'b000;
        bus_if.out_ready = 1'b1;

        #2;
        checkOutput("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        checkOutput("rst_out_data", bus_if.out_data, 32'd0);
        checkOutput("rst_out_rel", {30'd0, bus_if.out_rel}, 32'd0);
        checkOutput("rst_out_nv", {31'd0, bus_if.out_nv}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready_low", {31'd0, bus_if.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("release_in_ready_high", {31'd0, bus_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] vector table");
        for (int i = 0; i < 20; i++) runVector(vecs[i]);

        $display("[TB] stall sequence");
        stallSequence();

        $display("[TB] flush sequence");
        bus_if.out_ready = 1'b0;
        applyStimulus(vecs[0].a, vecs[0].b, vecs[0].op);
        applyStimulus(vecs[7].a, vecs[7].b, vecs[7].op);
        flush = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.a_operand = vecs[5].a;
        bus_if.b_operand = vecs[5].b;
        bus_if.op = vecs[5].op;
        @(posedge clk);
        #1 flush = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("flush_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkQuiet("flush_no_stale", 4);
        flush = 1'b1;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        bus_if.in_valid = 1'b0;
        checkQuiet("flush_drops_transfer", 4);
        runVector(vecs[0]);

        $display("[TB] reset pulse");
        bus_if.out_ready = 1'b0;
        applyStimulus(vecs[5].a, vecs[5].b, vecs[5].op);
        @(posedge clk);
        #1;
        checkOutput("prereset_valid", {31'd0, bus_if.out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        checkOutput("midrst_out_data", bus_if.out_data, 32'd0);
        checkOutput("midrst_out_rel", {30'd0, bus_if.out_rel}, 32'd0);
        checkOutput("midrst_out_nv", {31'd0, bus_if.out_nv}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready_low", {31'd0, bus_if.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midrst_no_stale", {31'd0, bus_if.out_valid}, 32'd0);
        checkOutput("midrst_in_ready_high", {31'd0, bus_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        runVector(vecs[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
